// File: rtl/qpsk_demod.sv
// QPSK hard-decision demodulator: sign slicing plus weak-component flag, buffered in a 2-entry FIFO.
// Optional saturating weak-symbol counter is enabled by defining QPSK_DEMOD_WEAK_CNT_EN.
module qpsk_demod #(
  parameter int unsigned W      = 12,
  parameter int unsigned THRESH = 724
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_i,
  output logic                out_q,
  output logic                out_weak,
  output logic                out_valid,
  input  logic                out_ready
`ifdef QPSK_DEMOD_WEAK_CNT_EN
  ,
  output logic [15:0]         weak_cnt,
  input  logic                weak_clr
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned DW    = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SMAX = ~SMIN;

  // Absolute value; the most negative code saturates to the most positive one.
  function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
    if (x == SMIN)
      return SMAX;
    else if (x[W-1])
      return W'(-x);
    else
      return x;
  endfunction

  logic [W-1:0]  w_mag_i;
  logic [W-1:0]  w_mag_q;
  logic          w_weak;
  logic [DW-1:0] w_dec;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_head;

  logic [DW-1:0] r_mem [DEPTH];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  // Decision: sign bit gives the hard bit (zero decides 0), magnitudes give the weak flag.
  always_comb begin
    w_mag_i = sat_abs($unsigned(in_i));
    w_mag_q = sat_abs($unsigned(in_q));
    w_weak  = (32'(w_mag_i) < THRESH) || (32'(w_mag_q) < THRESH);
    w_dec   = {in_i[W-1], in_q[W-1], w_weak};
  end

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // Head of the FIFO drives the outputs; forced low while empty so reset values hold.
  assign out_i    = out_valid & w_head[2];
  assign out_q    = out_valid & w_head[1];
  assign out_weak = out_valid & w_head[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef QPSK_DEMOD_WEAK_CNT_EN
  logic [CNT_W-1:0] r_weak_cnt;

  // Clear wins over a same-edge increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_weak_cnt <= '0;
    else if (weak_clr)
      r_weak_cnt <= '0;
    else if (w_push && w_weak && (r_weak_cnt != {CNT_W{1'b1}}))
      r_weak_cnt <= r_weak_cnt + CNT_W'(1);
  end

  assign weak_cnt = r_weak_cnt;
`endif

endmodule

// File: tb/tb_qpsk_demod.sv
// Self-checking bench for qpsk_demod: directed corner symbols, backpressure, reset, random streams.
// Counter checks are compiled in when QPSK_DEMOD_WEAK_CNT_EN is defined.
module tb_qpsk_demod;

  localparam int unsigned W      = 12;
  localparam int unsigned THRESH = 724;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;
  logic                in_valid;
  logic                in_ready;
  logic                out_i;
  logic                out_q;
  logic                out_weak;
  logic                out_valid;
  logic                out_ready;
`ifdef QPSK_DEMOD_WEAK_CNT_EN
  logic [15:0]         weak_cnt;
  logic                weak_clr;
`endif

  always #5 clk = ~clk;

  qpsk_demod #(.W(W), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_i      (in_i),
    .in_q      (in_q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_weak  (out_weak),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef QPSK_DEMOD_WEAK_CNT_EN
    ,
    .weak_cnt  (weak_cnt),
    .weak_clr  (weak_clr)
`endif
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] mq[$];
  int         mcnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mag(input int x);
    if (x == -(1 << (W - 1)))
      return (1 << (W - 1)) - 1;
    return (x < 0) ? -x : x;
  endfunction

  // Reference decision {bit_i, bit_q, weak} straight from the sample values.
  function automatic logic [2:0] decide(input int si, input int sq);
    logic bi, bq, wk;
    bi = (si < 0);
    bq = (sq < 0);
    wk = (mag(si) < int'(THRESH)) || (mag(sq) < int'(THRESH));
    return {bi, bq, wk};
  endfunction

  function automatic int rsample();
    case ($urandom_range(0, 7))
      0:       return -2048;
      1:       return 2047;
      2:       return 0;
      3:       return int'(THRESH);
      4:       return int'(THRESH) - 1;
      5:       return -int'(THRESH);
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic drive(input int i, input int q, input bit v, input bit r);
    in_i      = W'(i);
    in_q      = W'(q);
    in_valid  = v;
    out_ready = r;
  endtask

  // One clock: compare DUT against the model just before the edge, then advance the model.
  task automatic step();
    bit         acc;
    bit         pop;
    logic [2:0] d;
    @(negedge clk);
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0)
      check_eq("head", 32'({out_i, out_q, out_weak}), 32'(mq[0]));
`ifdef QPSK_DEMOD_WEAK_CNT_EN
    check_eq("weak_cnt", 32'(weak_cnt), 32'(mcnt));
`endif
    acc = in_valid && (mq.size() < 2);
    pop = (mq.size() != 0) && out_ready;
    d   = decide(int'(in_i), int'(in_q));
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(d);
`ifdef QPSK_DEMOD_WEAK_CNT_EN
    if (weak_clr) mcnt = 0;
    else if (acc && d[0] && mcnt < 65535) mcnt++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_out", 32'({out_valid, out_i, out_q, out_weak}), 32'(0));
`ifdef QPSK_DEMOD_WEAK_CNT_EN
    check_eq("rst_cnt", 32'(weak_cnt), 32'(0));
`endif
    mq.delete();
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  // Single symbol into an empty FIFO: must show up one edge later with the given bits.
  task automatic directed(input string tag, input int i, input int q, input logic [2:0] exp);
    drive(i, q, 1'b1, 1'b1);
    step();
    drive(0, 0, 1'b0, 1'b1);
    check_eq(tag, 32'({out_valid, out_i, out_q, out_weak}), 32'({1'b1, exp}));
    step();
  endtask

  initial begin
    drive(0, 0, 1'b0, 1'b0);
`ifdef QPSK_DEMOD_WEAK_CNT_EN
    weak_clr = 1'b0;
`endif
    do_reset();

    directed("pp",  1447,  1447, 3'b000);
    directed("pn",  1447, -1447, 3'b010);
    directed("np", -1447,  1447, 3'b100);
    directed("nn", -1447, -1447, 3'b110);
    directed("zero_min", 0, -2048, 3'b011);
    directed("eq_thresh", 724, -724, 3'b010);
    directed("below_thresh", 723, 900, 3'b001);
    directed("min_min", -2048, -2048, 3'b110);

    // Backpressure: three offered, two accepted, drained in order.
    drive(1000, 1000, 1'b1, 1'b0);   step();
    drive(-1000, 1000, 1'b1, 1'b0);  step();
    drive(1000, -1000, 1'b1, 1'b0);  step();
    check_eq("full_in_ready", 32'(in_ready), 32'(0));
    drive(0, 0, 1'b0, 1'b1);
    check_eq("bp_first", 32'({out_valid, out_i, out_q, out_weak}), 32'(4'b1000));
    step();
    check_eq("bp_second", 32'({out_valid, out_i, out_q, out_weak}), 32'(4'b1100));
    step();
    check_eq("bp_empty", 32'(out_valid), 32'(0));
    step();

    // Continuous flow: one symbol per cycle.
    for (int k = 0; k < 200; k++) begin
      drive(rsample(), rsample(), 1'b1, 1'b1);
      step();
    end
    drive(0, 0, 1'b0, 1'b1);
    repeat (2) step();

    // Random valid/ready.
    for (int k = 0; k < 400; k++) begin
      drive(rsample(), rsample(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      step();
    end
    drive(0, 0, 1'b0, 1'b1);
    repeat (3) step();

    // Reset with two entries buffered.
    drive(-1500, -1500, 1'b1, 1'b0); step();
    drive(1500, 1500, 1'b1, 1'b0);   step();
    drive(0, 0, 1'b0, 1'b0);
    check_eq("pre_rst_full", 32'(in_ready), 32'(0));
    do_reset();
    directed("post_rst", 1500, -1500, 3'b010);

`ifdef QPSK_DEMOD_WEAK_CNT_EN
    for (int k = 0; k < 70000; k++) begin
      drive(0, -2048, 1'b1, 1'b1);
      step();
    end
    check_eq("cnt_sat", 32'(weak_cnt), 32'(65535));
    weak_clr = 1'b1;
    drive(100, 100, 1'b1, 1'b1);
    step();
    weak_clr = 1'b0;
    drive(0, 0, 1'b0, 1'b1);
    check_eq("cnt_clr", 32'(weak_cnt), 32'(0));
    directed("cnt_one", -10, 2000, 3'b101);
    check_eq("cnt_after", 32'(weak_cnt), 32'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qpsk_demod.md
QPSK_DEMOD -- requirements
Module: qpsk_demod

Interface
REQ-001 SHALL have parameter W, default 12, meaning the signed I/Q sample width.
REQ-002 SHALL have parameter THRESH, default 724, meaning the unsigned magnitude below which a component is weak.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 SHALL have port in_i, input, W, the signed I sample.
REQ-006 SHALL have port in_q, input, W, the signed Q sample.
REQ-007 SHALL have port in_valid, input, 1, meaning the sample pair is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a sample pair this cycle.
REQ-009 SHALL have port out_i, output, 1, the decided I bit.
REQ-010 SHALL have port out_q, output, 1, the decided Q bit.
REQ-011 SHALL have port out_weak, output, 1, set when the emitted symbol had a weak component.
REQ-012 SHALL have port out_valid, output, 1, meaning out_i, out_q and out_weak are valid.
REQ-013 SHALL have port out_ready, input, 1, meaning the downstream accepts the output.
REQ-014 SHALL have port weak_cnt, output, 16, the saturating count of weak symbols (only with macro).
REQ-015 SHALL have port weak_clr, input, 1, a synchronous clear of weak_cnt (only with macro).

Function
REQ-016 SHALL accept a symbol when in_valid and in_ready are high on the same edge.
REQ-017 SHALL decide out_i = 1 if in_i < 0, else 0; zero decides 0.
REQ-018 SHALL decide out_q = 1 if in_q < 0, else 0; zero decides 0.
REQ-019 SHALL compute the magnitude of each component as an absolute value, with -2^(W-1) saturating to 2^(W-1)-1.
REQ-020 SHALL set weak = (|in_i| < THRESH) or (|in_q| < THRESH); a magnitude equal to THRESH is not weak.
REQ-021 SHALL store each decision {out_i, out_q, weak} in a 2-entry FIFO; the head drives the outputs.
REQ-022 SHALL drive in_ready combinationally from FIFO occupancy only: high when fewer than 2 entries are held.
REQ-023 SHALL have latency of 1 cycle: a symbol accepted at edge N is visible with out_valid high after edge N.
REQ-024 SHALL set out_valid high whenever the FIFO is non-empty.
REQ-025 SHALL pop the FIFO when out_valid and out_ready are both high.
REQ-026 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve ordering; with 2 entries held, in_ready stays low even if out_ready is high that cycle.
REQ-027 SHALL hold out_i, out_q and out_weak stable while out_valid is high and out_ready is low.
REQ-028 SHALL use FIFO pointers that wrap modulo 2, with occupancy tracked by a 2-bit count of 0..2.
REQ-029 SHALL never drop or duplicate a symbol.

Reset
REQ-030 SHALL, when rst is asserted, immediately set out_valid=0, out_i=0, out_q=0, out_weak=0, weak_cnt=0, FIFO empty, and in_ready=1 after rst is released.
REQ-031 SHALL discard buffered symbols on a reset asserted mid-operation; the first symbol accepted after release is the first emitted.

Configuration
REQ-032 SHALL, with QPSK_DEMOD_WEAK_CNT_EN defined, increment weak_cnt on each accepted weak symbol, saturating at 65535; weak_clr has priority over an increment on the same edge.
REQ-033 SHALL, without QPSK_DEMOD_WEAK_CNT_EN, omit weak_cnt and weak_clr; out_weak remains present.

Verification
REQ-034 SHALL cover: (1447,1447) -> bits 00; (1447,-1447) -> 01; (-1447,1447) -> 10; (-1447,-1447) -> 11; all with weak=0 and 1-cycle latency.
REQ-035 SHALL cover: (0,-2048) -> bits 01, weak=1; (724,-724) -> weak=0; (723,900) -> weak=1.
REQ-036 SHALL cover: out_ready=0 and 3 symbols offered -> 2 accepted, in_ready low; then out_ready=1 -> emitted in order with no loss.
REQ-037 SHALL cover: in_valid=1 and out_ready=1 continuously with a random sample stream -> one symbol per cycle, output equal to the decision model.
REQ-038 SHALL cover: rst asserted with 2 entries buffered -> out_valid=0 at once; after release, the next symbol is the first emitted.
REQ-039 SHALL cover (macro on): 70000 weak symbols -> weak_cnt=65535; weak_clr together with a weak symbol -> weak_cnt=0.
